// File: rtl/uart_rx_bit_sampler.sv
// ---------------------------------------------------------------------------
// uart_rx_bit_sampler
//
// Receive-side oversampling sequencer for a UART. It watches the synchronised
// serial line for a start edge, counts oversample ticks from the baud-rate
// enable and produces one registered strobe per frame bit (start, data, stop)
// with the sampled value, the bit position and the frame status.
//
// Optional feature (compile-time macro): UART_RX_MAJORITY_EN
//   When defined, each bit is taken as the 2-of-3 majority of the line at
//   phases SAMPLE_POINT-1, SAMPLE_POINT and SAMPLE_POINT+1, and is decided on
//   the SAMPLE_POINT+1 tick. When undefined, the line is sampled once at
//   phase SAMPLE_POINT.
//
// Ports:
//   CLK        in   system clock, rising edge
//   RST        in   synchronous active-high reset
//   UART_CE    in   oversample tick, one CLK wide
//   RXD        in   synchronised serial input, idle high
//   RXCT_R     in   synchronous abort/clear from RX control
//   RX_CE      out  one-cycle strobe: a bit has been sampled
//   RX_BIT     out  sampled bit value, valid with RX_CE
//   BIT_IDX    out  frame position: 0=start, 1..DATA_BITS=data, DATA_BITS+1=stop
//   BUSY       out  high whenever the sequencer is not idle
//   START_ERR  out  one-cycle pulse on a false start
//   FRAME_DONE out  one-cycle pulse with the stop-bit strobe
//   FRAME_ERR  out  one-cycle pulse with FRAME_DONE when the stop bit was 0
// ---------------------------------------------------------------------------
module uart_rx_bit_sampler #(
    parameter int OVERSAMPLE   = 16,
    parameter int SAMPLE_POINT = 7,
    parameter int DATA_BITS    = 8
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic                           UART_CE,
    input  logic                           RXD,
    input  logic                           RXCT_R,
    output logic                           RX_CE,
    output logic                           RX_BIT,
    output logic [$clog2(DATA_BITS+2)-1:0] BIT_IDX,
    output logic                           BUSY,
    output logic                           START_ERR,
    output logic                           FRAME_DONE,
    output logic                           FRAME_ERR
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam int IW = $clog2(DATA_BITS + 2);

    localparam logic [CW-1:0] CNT_LAST = CW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
    localparam logic [CW-1:0] EARLY_PT  = CW'(SAMPLE_POINT - 1);
    localparam logic [CW-1:0] MID_PT    = CW'(SAMPLE_POINT);
    localparam logic [CW-1:0] DECIDE_PT = CW'(SAMPLE_POINT + 1);
`else
    localparam logic [CW-1:0] DECIDE_PT = CW'(SAMPLE_POINT);
`endif
    localparam logic [IW-1:0] LAST_DATA_IDX = IW'(DATA_BITS);
    localparam logic [IW-1:0] STOP_IDX      = IW'(DATA_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [IW-1:0] dataIdx_q;
    logic [IW-1:0] bitIdx_q;
    logic          rxCe_q;
    logic          rxBit_q;
    logic          busy_q;
    logic          startErr_q;
    logic          frameDone_q;
    logic          frameErr_q;
    logic          sampleBit;

    // Phase counter advance: wraps at the end of the bit period with no
    // saturation, so consecutive decision ticks are exactly one bit apart.
    assign cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;

`ifdef UART_RX_MAJORITY_EN
    logic early_q;
    logic mid_q;

    // Capture the line on the two ticks before the decision tick; the third
    // vote is the live line on the decision tick itself. In IDLE the counter
    // sits at 0, so with SAMPLE_POINT=1 the early vote is the start-edge tick.
    always_ff @(posedge CLK) begin
        if (RST || RXCT_R) begin
            early_q <= 1'b0;
            mid_q   <= 1'b0;
        end else if (UART_CE) begin
            if (cnt_q == EARLY_PT) begin
                early_q <= RXD;
            end
            if (cnt_q == MID_PT) begin
                mid_q <= RXD;
            end
        end
    end

    assign sampleBit = (early_q & mid_q) | (early_q & RXD) | (mid_q & RXD);
`else
    assign sampleBit = RXD;
`endif

    // Main sequencer. Abort shares the reset path so an abort on a decision
    // tick suppresses the strobe. Pulses default low every cycle; BIT_IDX and
    // RX_BIT hold between strobes. STOP returns to IDLE on its own decision
    // tick so the very next tick can detect a new start edge.
    always_ff @(posedge CLK) begin
        if (RST || RXCT_R) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            dataIdx_q   <= '0;
            bitIdx_q    <= '0;
            rxCe_q      <= 1'b0;
            rxBit_q     <= 1'b0;
            busy_q      <= 1'b0;
            startErr_q  <= 1'b0;
            frameDone_q <= 1'b0;
            frameErr_q  <= 1'b0;
        end else begin
            rxCe_q      <= 1'b0;
            startErr_q  <= 1'b0;
            frameDone_q <= 1'b0;
            frameErr_q  <= 1'b0;
            if (UART_CE) begin
                case (state_q)
                    IDLE: begin
                        cnt_q <= '0;
                        if (!RXD) begin
                            state_q <= START;
                            cnt_q   <= CW'(1);
                            busy_q  <= 1'b1;
                        end
                    end
                    START: begin
                        cnt_q <= cnt_d;
                        if (cnt_q == DECIDE_PT) begin
                            if (sampleBit) begin
                                startErr_q <= 1'b1;
                                state_q    <= IDLE;
                                cnt_q      <= '0;
                                busy_q     <= 1'b0;
                            end else begin
                                rxCe_q    <= 1'b1;
                                rxBit_q   <= 1'b0;
                                bitIdx_q  <= '0;
                                dataIdx_q <= IW'(1);
                                state_q   <= DATA;
                            end
                        end
                    end
                    DATA: begin
                        cnt_q <= cnt_d;
                        if (cnt_q == DECIDE_PT) begin
                            rxCe_q   <= 1'b1;
                            rxBit_q  <= sampleBit;
                            bitIdx_q <= dataIdx_q;
                            if (dataIdx_q == LAST_DATA_IDX) begin
                                state_q <= STOP;
                            end else begin
                                dataIdx_q <= dataIdx_q + 1'b1;
                            end
                        end
                    end
                    STOP: begin
                        cnt_q <= cnt_d;
                        if (cnt_q == DECIDE_PT) begin
                            rxCe_q      <= 1'b1;
                            rxBit_q     <= sampleBit;
                            bitIdx_q    <= STOP_IDX;
                            frameDone_q <= 1'b1;
                            frameErr_q  <= ~sampleBit;
                            state_q     <= IDLE;
                            cnt_q       <= '0;
                            busy_q      <= 1'b0;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign RX_CE      = rxCe_q;
    assign RX_BIT     = rxBit_q;
    assign BIT_IDX    = bitIdx_q;
    assign BUSY       = busy_q;
    assign START_ERR  = startErr_q;
    assign FRAME_DONE = frameDone_q;
    assign FRAME_ERR  = frameErr_q;

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_bit_sampler
//
// Directed bench for uart_rx_bit_sampler. Instance A uses default parameters
// with UART_CE every cycle; instance B uses OVERSAMPLE=8, SAMPLE_POINT=3,
// DATA_BITS=7 with UART_CE every third cycle. Expected strobes are queued
// when a frame is driven and compared as the strobes appear.
// ---------------------------------------------------------------------------
module tb_uart_rx_bit_sampler;

`ifdef UART_RX_MAJORITY_EN
   localparam int LAT_A       = 9;
   localparam bit GLITCH_FLIP = 1'b0;
`else
   localparam int LAT_A       = 8;
   localparam bit GLITCH_FLIP = 1'b1;
`endif

   logic clk;
   logic rst;

   logic       ceA, rxdA, rxctA;
   logic       rxCeA, rxBitA, busyA, startErrA, frameDoneA, frameErrA;
   logic [3:0] bitIdxA;

   logic       ceB, rxdB, rxctB;
   logic       rxCeB, rxBitB, busyB, startErrB, frameDoneB, frameErrB;
   logic [3:0] bitIdxB;

   int checks = 0;
   int errors = 0;
   int extraA = 0;
   int extraB = 0;
   int startErrCntA = 0;
   int startErrCntB = 0;
   int doneCntA = 0;
   int doneCntB = 0;

   logic [6:0] qA[$];
   logic [6:0] qB[$];
   logic [6:0] expA;
   logic [6:0] expB;
   time        tA[$];
   time        tStartA;

   uart_rx_bit_sampler dutA (
      .CLK(clk), .RST(rst), .UART_CE(ceA), .RXD(rxdA), .RXCT_R(rxctA),
      .RX_CE(rxCeA), .RX_BIT(rxBitA), .BIT_IDX(bitIdxA), .BUSY(busyA),
      .START_ERR(startErrA), .FRAME_DONE(frameDoneA), .FRAME_ERR(frameErrA)
   );

   uart_rx_bit_sampler #(
      .OVERSAMPLE(8), .SAMPLE_POINT(3), .DATA_BITS(7)
   ) dutB (
      .CLK(clk), .RST(rst), .UART_CE(ceB), .RXD(rxdB), .RXCT_R(rxctB),
      .RX_CE(rxCeB), .RX_BIT(rxBitB), .BIT_IDX(bitIdxB), .BUSY(busyB),
      .START_ERR(startErrB), .FRAME_DONE(frameDoneB), .FRAME_ERR(frameErrB)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Scoreboard monitor for instance A: pops one expected entry per strobe.
   always @(negedge clk) begin
      if (rxCeA) begin
         tA.push_back($time);
         if (qA.size() == 0) begin
            extraA++;
         end else begin
            expA = qA.pop_front();
            checkOutput("A_strobe", {9'b0, bitIdxA, rxBitA, frameDoneA, frameErrA}, {9'b0, expA});
         end
      end
      if (startErrA) startErrCntA++;
      if (frameDoneA) doneCntA++;
   end

   // Scoreboard monitor for instance B.
   always @(negedge clk) begin
      if (rxCeB) begin
         if (qB.size() == 0) begin
            extraB++;
         end else begin
            expB = qB.pop_front();
            checkOutput("B_strobe", {9'b0, bitIdxB, rxBitB, frameDoneB, frameErrB}, {9'b0, expB});
         end
      end
      if (startErrB) startErrCntB++;
      if (frameDoneB) doneCntB++;
   end

   // Hold a level on instance A's line for n ticks.
   task automatic driveA(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rxdA = v;
      end
   endtask

   // Drive one full frame into instance A, queueing the expected strobes.
   // glitchIdx selects a data bit whose sample-phase tick is inverted.
   task automatic applyStimulus(input logic [7:0] data, input logic stopVal, input int stopTicks, input int glitchIdx);
      logic bitVal;
      qA.push_back(7'b0);
      for (int i = 1; i <= 8; i++) begin
         qA.push_back({4'(i), data[i-1] ^ ((i == glitchIdx) ? GLITCH_FLIP : 1'b0), 2'b00});
      end
      qA.push_back({4'd9, stopVal, 1'b1, ~stopVal});
      for (int k = 0; k < 10; k++) begin
         if (k == 0) bitVal = 1'b0;
         else if (k <= 8) bitVal = data[k-1];
         else bitVal = stopVal;
         for (int t = 0; t < ((k == 9) ? stopTicks : 16); t++) begin
            @(negedge clk);
            rxdA = bitVal ^ ((k == glitchIdx && t == 7) ? 1'b1 : 1'b0);
            if (k == 0 && t == 0) tStartA = $time;
         end
      end
   endtask

   // One UART_CE tick on instance B: one cycle enabled, two cycles idle.
   task automatic tickB(input logic v);
      @(negedge clk);
      ceB  = 1'b1;
      rxdB = v;
      @(negedge clk);
      ceB = 1'b0;
      @(negedge clk);
   endtask

   // Drive one 7-bit frame into instance B with a full-length stop bit.
   task automatic applyStimulusNarrow(input logic [6:0] data);
      logic bitVal;
      qB.push_back(7'b0);
      for (int i = 1; i <= 7; i++) begin
         qB.push_back({4'(i), data[i-1], 2'b00});
      end
      qB.push_back({4'd8, 1'b1, 1'b1, 1'b0});
      for (int k = 0; k < 9; k++) begin
         if (k == 0) bitVal = 1'b0;
         else if (k <= 7) bitVal = data[k-1];
         else bitVal = 1'b1;
         for (int t = 0; t < 8; t++) tickB(bitVal);
      end
   endtask

   // Bounded wait for instance A's expected strobes to be consumed.
   task automatic waitDrainA(input string tag);
      for (int i = 0; i < 64 && qA.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      checkOutput(tag, 16'(qA.size()), 16'd0);
   endtask

   task automatic waitDrainB(input string tag);
      for (int i = 0; i < 64 && qB.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      checkOutput(tag, 16'(qB.size()), 16'd0);
   endtask

   initial begin
      rst   = 1'b1;
      ceA   = 1'b1;
      rxdA  = 1'b1;
      rxctA = 1'b0;
      ceB   = 1'b0;
      rxdB  = 1'b1;
      rxctB = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checkOutput("A_reset", {6'b0, rxCeA, rxBitA, bitIdxA, busyA, startErrA, frameDoneA, frameErrA}, 16'd0);
      checkOutput("B_reset", {6'b0, rxCeB, rxBitB, bitIdxB, busyB, startErrB, frameDoneB, frameErrB}, 16'd0);
      rst = 1'b0;
      driveA(1'b1, 4);

      // Frame 0x55, stop 1: latency and strobe spacing.
      tA.delete();
      applyStimulus(8'h55, 1'b1, 16, -1);
      waitDrainA("A_drain_55");
      checkOutput("A_strobe_count_55", 16'(tA.size()), 16'd10);
      if (tA.size() == 10) begin
         checkOutput("A_first_latency", 16'(int'(tA[0] - tStartA)), 16'(LAT_A * 10));
         checkOutput("A_strobe_span", 16'(int'(tA[9] - tA[0])), 16'd1440);
      end
      driveA(1'b1, 4);
      checkOutput("A_busy_idle_55", {15'b0, busyA}, 16'd0);

      // False start: three low ticks then high.
      driveA(1'b0, 3);
      driveA(1'b1, 20);
      #1;
      checkOutput("A_start_err_count", 16'(startErrCntA), 16'd1);
      checkOutput("A_busy_after_false", {15'b0, busyA}, 16'd0);
      checkOutput("A_no_strobe_false", 16'(extraA), 16'd0);

      applyStimulus(8'hA3, 1'b1, 16, -1);
      waitDrainA("A_drain_A3");

      // 0xFF with a bad stop bit, released right after its sample point.
      applyStimulus(8'hFF, 1'b0, 8, -1);
      driveA(1'b1, 1);
      waitDrainA("A_drain_FF");
      driveA(1'b1, 20);

      // Abort after data bit 4 of 0x5A.
      qA.push_back(7'b0);
      qA.push_back({4'd1, 1'b0, 2'b00});
      qA.push_back({4'd2, 1'b1, 2'b00});
      qA.push_back({4'd3, 1'b0, 2'b00});
      qA.push_back({4'd4, 1'b1, 2'b00});
      driveA(1'b0, 16);
      driveA(1'b0, 16);
      driveA(1'b1, 16);
      driveA(1'b0, 16);
      driveA(1'b1, 1);
      for (int i = 0; i < 40 && qA.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      checkOutput("A_abort_wait", 16'(qA.size()), 16'd0);
      rxctA = 1'b1;
      @(negedge clk);
      rxctA = 1'b0;
      #1;
      checkOutput("A_abort_busy", {15'b0, busyA}, 16'd0);
      checkOutput("A_abort_idx", {12'b0, bitIdxA}, 16'd0);
      driveA(1'b1, 200);
      checkOutput("A_abort_no_more", 16'(extraA), 16'd0);

      // Reset mid-frame, right after the data bit 1 strobe.
      qA.push_back(7'b0);
      qA.push_back({4'd1, 1'b1, 2'b00});
      driveA(1'b0, 16);
      driveA(1'b1, 1);
      for (int i = 0; i < 40 && qA.size() != 0; i++) begin
         @(negedge clk);
         #1;
      end
      checkOutput("A_rst_wait", 16'(qA.size()), 16'd0);
      rst = 1'b1;
      @(negedge clk);
      #1;
      checkOutput("A_rst_mid", {6'b0, rxCeA, rxBitA, bitIdxA, busyA, startErrA, frameDoneA, frameErrA}, 16'd0);
      rst = 1'b0;
      driveA(1'b1, 200);

      // Glitch on the sample phase of data bit 2 of 0x96.
      applyStimulus(8'h96, 1'b1, 16, 2);
      waitDrainA("A_drain_glitch");
      driveA(1'b1, 4);

      // Instance B: two back-to-back frames.
      applyStimulusNarrow(7'h41);
      applyStimulusNarrow(7'h3C);
      for (int i = 0; i < 8; i++) tickB(1'b1);
      waitDrainB("B_drain");
      checkOutput("B_busy_idle", {15'b0, busyB}, 16'd0);

      checkOutput("A_extra_strobes", 16'(extraA), 16'd0);
      checkOutput("B_extra_strobes", 16'(extraB), 16'd0);
      checkOutput("A_frames_done", 16'(doneCntA), 16'd4);
      checkOutput("B_frames_done", 16'(doneCntB), 16'd2);
      checkOutput("A_start_err_total", 16'(startErrCntA), 16'd1);
      checkOutput("B_start_err_total", 16'(startErrCntB), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
